// File: rtl/nand_logic_unit_pkg.sv
// Shared definitions for the NAND logic unit: mode select width and encodings.
package nlu_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_NOT  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_BUF  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_AND  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_OR   = 3'b011;
    localparam logic [MODE_W-1:0] MODE_NAND = 3'b100;
    localparam logic [MODE_W-1:0] MODE_NOR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_XOR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_XNOR = 3'b111;

endpackage

// File: rtl/nand_logic_unit_if.sv
// Operand/result bus of the NAND logic unit; master drives beats and accepts results.
interface nand_logic_unit_if #(
    parameter int WIDTH = 8
);
    import nlu_pkg::*;

    // Both channels use valid/ready: a transfer happens on a rising clk edge
    // where valid && ready; the sender holds its payload stable while valid && !ready.
    logic              in_valid;
    logic              in_ready;
    logic [MODE_W-1:0] in_mode;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_y;

    modport master (
        output in_valid, in_mode, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y
    );

endinterface

// File: rtl/nand_logic_unit_nand2_vec.sv
// Bitwise 2-input NAND primitive; the only place a NAND is expressed in the unit.
module nand2_vec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = ~(a & b);

endmodule

// File: rtl/nand_logic_unit.sv
// Registered bitwise logic unit built from a NAND network, with one output stage.
// Optional transfer counter on port op_count when NLU_OPCOUNT_EN is defined.
module nand_logic_unit
    import nlu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nand_logic_unit_if.slave     bus
`ifdef NLU_OPCOUNT_EN
    ,
    output logic [CNT_W-1:0]     op_count
`endif
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("nand_logic_unit: WIDTH must be in 1..64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("nand_logic_unit: CNT_W must be at least 1");
    end

    logic [WIDTH-1:0] n_aa, n_bb, n_ab;
    logic [WIDTH-1:0] buf_y, and_y, or_y, nor_y;
    logic [WIDTH-1:0] x_a, x_b, xor_y, xnor_y;

    // Each node is one NAND; a self-NAND is the inverter.
    nand2_vec #(.WIDTH(WIDTH)) u_not_a  (.a(bus.in_a), .b(bus.in_a), .y(n_aa));
    nand2_vec #(.WIDTH(WIDTH)) u_not_b  (.a(bus.in_b), .b(bus.in_b), .y(n_bb));
    nand2_vec #(.WIDTH(WIDTH)) u_nand   (.a(bus.in_a), .b(bus.in_b), .y(n_ab));
    nand2_vec #(.WIDTH(WIDTH)) u_buf    (.a(n_aa),     .b(n_aa),     .y(buf_y));
    nand2_vec #(.WIDTH(WIDTH)) u_and    (.a(n_ab),     .b(n_ab),     .y(and_y));
    nand2_vec #(.WIDTH(WIDTH)) u_or     (.a(n_aa),     .b(n_bb),     .y(or_y));
    nand2_vec #(.WIDTH(WIDTH)) u_nor    (.a(or_y),     .b(or_y),     .y(nor_y));
    // Classic 4-NAND XOR sharing the first NAND(A,B) node.
    nand2_vec #(.WIDTH(WIDTH)) u_xor_a  (.a(bus.in_a), .b(n_ab),     .y(x_a));
    nand2_vec #(.WIDTH(WIDTH)) u_xor_b  (.a(bus.in_b), .b(n_ab),     .y(x_b));
    nand2_vec #(.WIDTH(WIDTH)) u_xor    (.a(x_a),      .b(x_b),      .y(xor_y));
    nand2_vec #(.WIDTH(WIDTH)) u_xnor   (.a(xor_y),    .b(xor_y),    .y(xnor_y));

    logic [WIDTH-1:0] f_y;

    always_comb begin
        f_y = n_aa;
        case (bus.in_mode)
            MODE_NOT:  f_y = n_aa;
            MODE_BUF:  f_y = buf_y;
            MODE_AND:  f_y = and_y;
            MODE_OR:   f_y = or_y;
            MODE_NAND: f_y = n_ab;
            MODE_NOR:  f_y = nor_y;
            MODE_XOR:  f_y = xor_y;
            MODE_XNOR: f_y = xnor_y;
            default:   f_y = n_aa;
        endcase
    end

    logic             valid_q;
    logic [WIDTH-1:0] y_q;
    logic             accept;
    logic             drain;

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign drain         = valid_q && bus.out_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_y     = y_q;

    // Accept wins over drain so a full stage with out_ready=1 refills in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            y_q     <= f_y;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

`ifdef NLU_OPCOUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (drain) begin
            op_count <= op_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_nand_logic_unit.sv
// Self-checking bench for nand_logic_unit: queue-based reference model, per-cycle
// compare process, directed literal checks and randomized traffic.
module tb_nand_logic_unit;

    localparam int W = 8;
`ifdef NLU_OPCOUNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;
    bit   started;

    nand_logic_unit_if #(.WIDTH(W)) bus ();

`ifdef NLU_OPCOUNT_EN
    logic [CNT_W-1:0] op_count;
`endif

    nand_logic_unit #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef NLU_OPCOUNT_EN
        ,
        .op_count (op_count)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_f(input logic [2:0] m, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (m)
            3'd0: return ~a;
            3'd1: return a;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_y;
    int           exp_cnt;

    always @(posedge clk) begin
        bit drn, acc;
        if (!rst_n) begin
            exp_q.delete();
            last_y  = '0;
            exp_cnt = 0;
        end else begin
            drn = (exp_q.size() != 0) && bus.out_ready;
            acc = bus.in_valid && ((exp_q.size() == 0) || bus.out_ready);
            if (drn) begin
                void'(exp_q.pop_front());
                exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            end
            if (acc) begin
                last_y = ref_f(bus.in_mode, bus.in_a, bus.in_b);
                exp_q.push_back(last_y);
            end
        end
        started = 1'b1;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started) begin
            check("cmp_out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            check("cmp_out_y", 64'(bus.out_y), 64'(last_y));
            check("cmp_in_ready", 64'(bus.in_ready),
                  64'((exp_q.size() == 0) || bus.out_ready));
`ifdef NLU_OPCOUNT_EN
            check("cmp_op_count", 64'(op_count), 64'(exp_cnt));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        @(negedge clk);
        #1 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present a beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        bit r;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_mode  = m;
            bus.in_a     = a;
            bus.in_b     = b;
            #1 r = bus.in_ready;
            @(posedge clk);
            if (r) return;
        end
        check("send_beat_timeout", 64'd0, 64'd1);
    endtask

    task automatic drop_valid();
        #1 bus.in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] mode_tab [8];

    initial begin
        mode_tab = '{8'h5A, 8'hA5, 8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66};
        checks = 0;
        fails  = 0;
        started = 1'b0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 3'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        // Reset then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_y", 64'(bus.out_y), 64'h00);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef NLU_OPCOUNT_EN
        check("reset_op_count", 64'(op_count), 64'd0);
`endif

        // Single beat per mode with hand-computed results.
        for (int m = 0; m < 8; m++) begin
            check("model_pin", 64'(ref_f(3'(m), 8'hA5, 8'h3C)), 64'(mode_tab[m]));
            send_beat(3'(m), 8'hA5, 8'h3C);
            @(negedge clk);
            check("mode_out_y", 64'(bus.out_y), 64'(mode_tab[m]));
            check("mode_out_valid", 64'(bus.out_valid), 64'd1);
            drop_valid();
        end
        @(negedge clk);

        // Stall: held result, new beat presented but ignored until out_ready.
        #1 bus.out_ready = 1'b0;
        send_beat(3'd0, 8'hF0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_out_y", 64'(bus.out_y), 64'h0F);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            #1;
            bus.in_valid = 1'b1;
            bus.in_mode  = 3'd4;
            bus.in_a     = 8'h12;
            bus.in_b     = 8'h34;
        end
        @(negedge clk);
        check("stall_hold_y", 64'(bus.out_y), 64'h0F);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_y", 64'(bus.out_y), 64'hEF);
        check("stall_release_valid", 64'(bus.out_valid), 64'd1);
        drop_valid();
        @(negedge clk);

        // Back-to-back XOR beats with out_ready held high.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("b2b_out_valid", 64'(bus.out_valid), 64'd1);
                check("b2b_out_y", 64'(bus.out_y), 64'(8'hFF ^ 8'((i - 1) * 8'h11)));
            end
            #1;
            bus.in_valid = 1'b1;
            bus.in_mode  = 3'd6;
            bus.in_a     = 8'(i * 8'h11);
            bus.in_b     = 8'hFF;
        end
        @(negedge clk);
        check("b2b_last_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_last_y", 64'(bus.out_y), 64'hCC);
        drop_valid();
        @(negedge clk);

        // Reset while stalled discards the pending result.
        #1 bus.out_ready = 1'b0;
        send_beat(3'd7, 8'h5A, 8'h5A);
        @(negedge clk);
        check("rst_stall_valid", 64'(bus.out_valid), 64'd1);
        check("rst_stall_y", 64'(bus.out_y), 64'hFF);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_y", 64'(bus.out_y), 64'h00);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_ghost", 64'(bus.out_valid), 64'd0);
        end

        // Randomized traffic checked by the compare process.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_mode   = 3'($urandom_range(0, 7));
            bus.in_a      = 8'($urandom);
            bus.in_b      = 8'($urandom);
        end
        #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

`ifdef NLU_OPCOUNT_EN
        // 17 drains wrap a 4-bit counter once.
        do_reset(2);
        #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_mode  = 3'($urandom_range(0, 7));
            bus.in_a     = 8'($urandom);
            bus.in_b     = 8'($urandom);
        end
        @(negedge clk);
        drop_valid();
        repeat (2) @(negedge clk);
        check("cnt_wrap", 64'(op_count), 64'd1);
        #1 bus.out_ready = 1'b0;
        send_beat(3'd2, 8'h0F, 8'hFF);
        @(negedge clk);
        check("cnt_accept_only", 64'(op_count), 64'd1);
        drop_valid();
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("cnt_after_drain", 64'(op_count), 64'd2);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule

// File: doc/nand_logic_unit.md
Name: nand_logic_unit

Overview:
Registered, parametrised successor to the single-bit NAND-built inverter. Applies one of eight bitwise logic functions to WIDTH-bit operands. Every function is built only from a 2-input NAND primitive array. Operands enter and results leave through valid/ready handshakes, with one output register stage. Intended as the reusable logic stage in the micro-project datapaths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.
CNT_W, 16, width of the optional transfer counter; used only when NLU_OPCOUNT_EN is defined.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
in_valid  input  1  operand/mode beat is valid.
in_ready  output  1  block can accept a beat this cycle.
in_mode  input  3  function select, sampled with the beat.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B; ignored by modes 000 and 001.
out_valid  output  1  out_y holds a result.
out_ready  input  1  downstream accepts the result.
out_y  output  WIDTH  registered result.
op_count  output  CNT_W  completed transfers; present only with NLU_OPCOUNT_EN.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_y=0, op_count=0.
  - Reset overrides any in-flight or stalled result; that result is discarded.
  - in_ready=1 in the first cycle after reset is released.
- Mode encoding, all bitwise over WIDTH bits:
  - 000 NOT A = nand(A,A)
  - 001 BUF A = nand(nand(A,A), nand(A,A))
  - 010 AND = not(nand(A,B))
  - 011 OR = nand(not A, not B)
  - 100 NAND
  - 101 NOR = not(OR)
  - 110 XOR = 4-NAND network
  - 111 XNOR = not(XOR)
- All eight encodings are legal; no error state.
- Rules for the NAND network:
  - Pure combinational; no ~, |, ^ or & operators outside the primitive.
  - Mode select is a mux after the network.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single stage, no skid).
  - Accept occurs when in_valid && in_ready.
  - On accept: out_y <= f(in_mode, in_a, in_b) and out_valid <= 1 at the next edge. Latency is exactly 1 cycle.
  - Drain occurs when out_valid && out_ready.
  - Drain without accept: out_valid <= 0; out_y holds its last value.
- Simultaneous drain and accept (full with out_ready=1): the new result replaces the old in the same edge and out_valid stays 1. Back-to-back throughput is 1 beat/clk.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0.
  - out_y and out_valid stay stable.
  - in_* values are ignored even when in_valid=1.
- in_valid while in_ready=0 is not an error; upstream must hold the beat.
- Width: no carry or extension; bit i of out_y depends only on bit i of A and B.

Optional Feature:
Macro NLU_OPCOUNT_EN.
- Defined:
  - op_count port exists.
  - op_count increments by 1 on every drain and wraps from 2^CNT_W-1 to 0.
  - Reset clears it to 0.
- Not defined: no op_count port and no counter register. All other behaviour is identical.

Decomposition:
- Shared package nlu_pkg holds:
  - mode localparams: MODE_NOT=3'b000, MODE_BUF, MODE_AND, MODE_OR, MODE_NAND, MODE_NOR, MODE_XOR, MODE_XNOR.
  - MODE_W=3.
- One sub-module: nand2_vec, a WIDTH-parametrised bitwise 2-input NAND primitive. It is the only place a NAND is expressed, and it is instantiated for each network node.
- Top level holds the mux, the output register, the handshake and the optional counter.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 clk and release -> out_valid=0, out_y=8'h00, in_ready=1, op_count=0.
- Single-beat modes: A=8'hA5, B=8'h3C, out_ready=1, one beat per mode -> one cycle after each accept, out_y is 5A, A5, 24, BD, DB, 42, 99, 66 for modes 000..111.
- Stall: accept A=8'hF0 in mode 000 with out_ready=0 for 3 cycles, while in_valid=1 with different data -> out_y=8'h0F stays stable and in_ready=0; after out_ready=1 the held beat is accepted on the next edge.
- Back-to-back: 4 consecutive beats with out_ready=1 -> 4 results on 4 consecutive cycles and out_valid never drops.
- Reset mid-stall: out_valid=1, out_ready=0, then pulse rst_n=0 -> out_valid=0 and out_y=0 at the next edge; the pending result never appears.
- Counter (NLU_OPCOUNT_EN, CNT_W=4): 17 drains -> op_count=1 (wrapped once); a cycle with accept and no drain leaves the count unchanged.
